// File: rtl/tile_compositor.sv
// 16x16 tile compositor: renders depth-tested sprite jobs into a tile buffer and streams it out.
// Optional: define TILE_COMPOSITOR_TRANSPARENCY_EN to skip zero texels from non-background jobs.
module tile_compositor (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_job_valid,
  output logic        o_job_ready,
  input  logic [4:0]  i_start_x,
  input  logic [4:0]  i_start_y,
  input  logic [7:0]  i_position_z,
  input  logic [7:0]  i_texture_idx,
  input  logic        i_tile_last,
  output logic        o_tex_rd_en,
  output logic [15:0] o_tex_addr,
  input  logic [15:0] i_tex_data,
  output logic        o_pix_valid,
  output logic [15:0] o_pix_data,
  output logic [7:0]  o_pix_idx,
  input  logic        i_pix_ready,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, RENDER, DRAIN, OUTPUT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  sx_q, sx_d, sy_q, sy_d;
  logic [7:0]  z_q, z_d, tex_q, tex_d;
  logic        last_q, last_d;
  logic        rd_en_q, rd_en_d;
  logic [15:0] addr_q, addr_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_idx_q, pend_idx_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [7:0]  pix_idx_q, pix_idx_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [15:0] col_mem [256];
  logic [7:0]  dep_mem [256];
  logic        wr_en;
  logic [7:0]  wr_idx;
  logic [15:0] wr_col;
  logic [7:0]  wr_dep;

  // Returns {in_range, texture address}; address is zero for pixels outside the sprite window.
  function automatic logic [16:0] tex_lookup(input logic [7:0] pix, input logic [4:0] sx,
                                             input logic [4:0] sy, input logic [7:0] tex);
    logic [5:0] u, v;
    u = {2'b00, pix[3:0]} + 6'd16 - {1'b0, sx};
    v = {2'b00, pix[7:4]} + 6'd16 - {1'b0, sy};
    if (u[5:4] == 2'b00 && v[5:4] == 2'b00) return {1'b1, tex, v[3:0], u[3:0]};
    else return 17'd0;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wr_en  = 1'b0;
    wr_idx = pend_idx_q;
    wr_col = i_tex_data;
    wr_dep = z_q;
    if (pend_q) begin
      wr_en = (z_q == 8'd0) || (z_q >= dep_mem[pend_idx_q]);
`ifdef TILE_COMPOSITOR_TRANSPARENCY_EN
      if (z_q != 8'd0 && i_tex_data == 16'h0000) wr_en = 1'b0;
`endif
    end else if (state_q == OUTPUT && pix_valid_q && i_pix_ready) begin
      wr_en  = 1'b1;
      wr_idx = pix_idx_q;
      wr_col = 16'h0000;
      wr_dep = 8'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    z_d         = z_q;
    tex_d       = tex_q;
    last_d      = last_q;
    rd_en_d     = 1'b0;
    addr_d      = 16'h0000;
    pend_d      = rd_en_q;
    pend_idx_d  = cnt_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_idx_d   = pix_idx_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (i_job_valid && ready_q) begin
          sx_d    = i_start_x;
          sy_d    = i_start_y;
          z_d     = i_position_z;
          tex_d   = i_texture_idx;
          last_d  = i_tile_last;
          cnt_d   = 8'd0;
          {rd_en_d, addr_d} = tex_lookup(8'd0, i_start_x, i_start_y, i_texture_idx);
          state_d = RENDER;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RENDER: begin
        if (cnt_q == 8'd255) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
          {rd_en_d, addr_d} = tex_lookup(cnt_q + 8'd1, sx_q, sy_q, tex_q);
        end
      end
      DRAIN: begin
        if (last_q) begin
          state_d     = OUTPUT;
          pix_valid_d = 1'b1;
          pix_idx_d   = 8'd0;
          pix_data_d  = col_mem[0];
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      OUTPUT: begin
        if (i_pix_ready) begin
          if (pix_idx_q == 8'd255) begin
            state_d     = IDLE;
            pix_valid_d = 1'b0;
            pix_idx_d   = 8'd0;
            pix_data_d  = 16'h0000;
            ready_d     = 1'b1;
            busy_d      = 1'b0;
          end else begin
            pix_idx_d  = pix_idx_q + 8'd1;
            pix_data_d = col_mem[pix_idx_q + 8'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      sx_q        <= 5'd0;
      sy_q        <= 5'd0;
      z_q         <= 8'd0;
      tex_q       <= 8'd0;
      last_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= 16'h0000;
      pend_q      <= 1'b0;
      pend_idx_q  <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 16'h0000;
      pix_idx_q   <= 8'd0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      z_q         <= z_d;
      tex_q       <= tex_d;
      last_q      <= last_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_idx_q   <= pix_idx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the tile buffer is deliberately not reset; a background job overwrites every entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      col_mem[wr_idx] <= wr_col;
      dep_mem[wr_idx] <= wr_dep;
    end
  end

  assign o_job_ready = ready_q;
  assign o_tex_rd_en = rd_en_q;
  assign o_tex_addr  = addr_q;
  assign o_pix_valid = pix_valid_q;
  assign o_pix_data  = pix_data_q;
  assign o_pix_idx   = pix_idx_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_tile_compositor.sv
// Scoreboarded bench for tile_compositor: a pixel-level tile model predicts texture reads and output pixels.
module tb_tile_compositor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_job_valid = 1'b0;
  logic        o_job_ready;
  logic [4:0]  i_start_x = '0;
  logic [4:0]  i_start_y = '0;
  logic [7:0]  i_position_z = '0;
  logic [7:0]  i_texture_idx = '0;
  logic        i_tile_last = 1'b0;
  logic        o_tex_rd_en;
  logic [15:0] o_tex_addr;
  logic [15:0] i_tex_data;
  logic        o_pix_valid;
  logic [15:0] o_pix_data;
  logic [7:0]  o_pix_idx;
  logic        i_pix_ready;
  logic        o_busy;

  tile_compositor dut (
    .clk(clk), .reset_n(reset_n),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_start_x(i_start_x), .i_start_y(i_start_y), .i_position_z(i_position_z),
    .i_texture_idx(i_texture_idx), .i_tile_last(i_tile_last),
    .o_tex_rd_en(o_tex_rd_en), .o_tex_addr(o_tex_addr), .i_tex_data(i_tex_data),
    .o_pix_valid(o_pix_valid), .o_pix_data(o_pix_data), .o_pix_idx(o_pix_idx),
    .i_pix_ready(i_pix_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int rdy_mode = 0;

  logic [15:0] ref_col [256];
  logic [7:0]  ref_dep [256];
  logic [15:0] exp_rd_q [$];
  logic [23:0] exp_pix_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Texture memory contents: texture 5 holds its address low byte, texture 0 is all zero.
  function automatic logic [15:0] tex_fn(input logic [15:0] a);
    if (a[15:8] == 8'h00) return 16'h0000;
    return {a[15:8] - 8'd5, a[7:0]};
  endfunction

  // Tile model: walk the 16x16 pixels, composite the sprite by depth, queue reads and pixels.
  task automatic model_job(input int sx, input int sy, input logic [7:0] z, input logic [7:0] tex,
                           input bit last, output int n);
    n = 0;
    for (int py = 0; py < 16; py++) begin
      for (int px = 0; px < 16; px++) begin
        int u, v, idx;
        logic [15:0] a, t;
        bit wr;
        u = px + 16 - sx;
        v = py + 16 - sy;
        idx = py * 16 + px;
        if (u >= 0 && u <= 15 && v >= 0 && v <= 15) begin
          a = {tex, v[3:0], u[3:0]};
          exp_rd_q.push_back(a);
          n++;
          t = tex_fn(a);
          wr = (z == 8'd0) || (z >= ref_dep[idx]);
`ifdef TILE_COMPOSITOR_TRANSPARENCY_EN
          if (z != 8'd0 && t == 16'h0000) wr = 1'b0;
`endif
          if (wr) begin
            ref_col[idx] = t;
            ref_dep[idx] = z;
          end
        end
      end
    end
    if (last) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] ii;
        ii = i[7:0];
        exp_pix_q.push_back({ii, ref_col[i]});
        ref_col[i] = 16'h0000;
        ref_dep[i] = 8'd0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, o_job_ready, 1);
    check({tag, "_tex_rd_en"}, o_tex_rd_en, 0);
    check({tag, "_tex_addr"}, o_tex_addr, 0);
    check({tag, "_pix_valid"}, o_pix_valid, 0);
    check({tag, "_pix_data"}, o_pix_data, 0);
    check({tag, "_pix_idx"}, o_pix_idx, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  // Offers a job and waits until it has been accepted; returns 0 on timeout.
  task automatic offer_job(input int sx, input int sy, input logic [7:0] z, input logic [7:0] tex,
                           input bit last, output bit got);
    @(posedge clk); #1;
    i_start_x = sx[4:0]; i_start_y = sy[4:0]; i_position_z = z;
    i_texture_idx = tex; i_tile_last = last; i_job_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (o_job_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL job_accept: ready never seen, required 1");
    end
    @(posedge clk); #1;
    i_job_valid = 1'b0;
    i_start_x = 5'($urandom); i_start_y = 5'($urandom);
    i_position_z = 8'($urandom); i_texture_idx = 8'($urandom); i_tile_last = 1'($urandom);
    rd_cnt = 0;
  endtask

  task automatic send_job(input int sx, input int sy, input logic [7:0] z, input logic [7:0] tex,
                          input bit last, output int seen);
    int nrd, lat;
    bit got;
    model_job(sx, sy, z, tex, last, nrd);
    offer_job(sx, sy, z, tex, last, got);
    lat = 20000;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (o_job_ready) begin lat = k; break; end
      if (k == 10) check("busy_running", o_busy, 1);
    end
    // Ready is low for 257 cycles; with the accepting cycle that is the 258-cycle job period.
    if (!last) check("job_latency", lat, 257);
    else check("tile_done_in_time", (lat < 20000), 1);
    check("read_count", rd_cnt, nrd);
    check("reads_outstanding", exp_rd_q.size(), 0);
    if (last) check("pixels_outstanding", exp_pix_q.size(), 0);
    seen = rd_cnt;
  endtask

  // Texture responder and read monitor: data is driven for the cycle after each read.
  initial begin : tex_side
    logic p;
    logic [15:0] pa;
    i_tex_data = 16'h0000;
    forever begin
      @(negedge clk);
      p = o_tex_rd_en;
      pa = o_tex_addr;
      if (p) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL tex_rd_unexpected: got addr %0h expected no read", pa);
        end else begin
          check("tex_addr", pa, exp_rd_q.pop_front());
        end
      end
      @(posedge clk); #1;
      i_tex_data = p ? tex_fn(pa) : 16'($urandom);
    end
  end

  initial begin : ready_side
    int cyc;
    cyc = 0;
    i_pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0: i_pix_ready = 1'b1;
        1: i_pix_ready = ((cyc / 3) % 2) == 0;
        default: i_pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : pix_side
    logic held_v;
    logic [7:0] h_idx;
    logic [15:0] h_data;
    logic [23:0] e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (o_pix_valid) begin
        if (held_v) begin
          check("pix_idx_stable", o_pix_idx, h_idx);
          check("pix_data_stable", o_pix_data, h_data);
        end
        if (i_pix_ready) begin
          held_v = 1'b0;
          if (exp_pix_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL pix_unexpected: got idx %0h expected no pixel", o_pix_idx);
          end else begin
            e = exp_pix_q.pop_front();
            check("pix_idx", o_pix_idx, e[23:16]);
            check("pix_data", o_pix_data, e[15:0]);
          end
        end else begin
          held_v = 1'b1;
          h_idx = o_pix_idx;
          h_data = o_pix_data;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int seen, sx, sy;
    logic [7:0] z;
    bit got, last;
    for (int i = 0; i < 256; i++) begin ref_col[i] = 16'h0; ref_dep[i] = 8'h0; end

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset_n = 1'b1;

    // Background alone: texel i lands on pixel i.
    send_job(16, 16, 8'd0, 8'h05, 1'b1, seen);
    check("bg_reads_256", seen, 256);

    // Offset sprite over background.
    send_job(16, 16, 8'd0, 8'h05, 1'b0, seen);
    send_job(20, 18, 8'd3, 8'h09, 1'b1, seen);
    check("sprite_reads_168", seen, 168);

    // Depth ordering, then equal depth where the later job wins.
    send_job(16, 16, 8'd0, 8'h05, 1'b0, seen);
    send_job(18, 18, 8'd5, 8'h07, 1'b0, seen);
    send_job(20, 20, 8'd2, 8'h08, 1'b1, seen);
    send_job(16, 16, 8'd0, 8'h05, 1'b0, seen);
    send_job(18, 18, 8'd5, 8'h07, 1'b0, seen);
    send_job(20, 20, 8'd5, 8'h08, 1'b1, seen);

    // Zero texels from a raised sprite.
    send_job(16, 16, 8'd0, 8'h05, 1'b0, seen);
    send_job(16, 16, 8'd4, 8'h00, 1'b1, seen);

    // Stalling output stream, then a tile that only a sprite touches.
    rdy_mode = 1;
    send_job(16, 16, 8'd0, 8'h05, 1'b1, seen);
    send_job(24, 24, 8'd1, 8'h06, 1'b1, seen);
    rdy_mode = 0;

    // No overlap at all.
    send_job(0, 5, 8'd1, 8'h03, 1'b0, seen);
    check("no_overlap_x_reads", seen, 0);
    send_job(7, 0, 8'd9, 8'h04, 1'b0, seen);
    check("no_overlap_y_reads", seen, 0);

    rdy_mode = 2;
    for (int k = 0; k < 14; k++) begin
      sx = $urandom_range(0, 31);
      sy = $urandom_range(0, 31);
      z = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      last = (k == 13) || ($urandom_range(0, 3) == 0);
      send_job(sx, sy, z, 8'($urandom), last, seen);
    end
    rdy_mode = 0;

    // Reset at render pixel 100 aborts the job.
    model_job(16, 16, 8'd0, 8'h05, 1'b0, seen);
    offer_job(16, 16, 8'd0, 8'h05, 1'b0, got);
    repeat (100) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_rd_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    send_job(16, 16, 8'd0, 8'h05, 1'b0, seen);
    send_job(20, 18, 8'd3, 8'h09, 1'b1, seen);

    repeat (5) @(negedge clk);
    check("final_reads_left", exp_rd_q.size(), 0);
    check("final_pixels_left", exp_pix_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_compositor.md
TILE_COMPOSITOR -- requirements
Module: tile_compositor

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock, rising edge); reset_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have job ports: i_job_valid input 1 (job offered); o_job_ready output 1 (job accepted when valid&ready); i_start_x input 5 (sprite window origin x, 16 = tile-aligned); i_start_y input 5 (sprite window origin y); i_position_z input 8 (depth, 0 = background); i_texture_idx input 8; i_tile_last input 1 (last job of current tile).
REQ-003 SHALL have texture read ports: o_tex_rd_en output 1; o_tex_addr output 16 ({texture_idx, v[3:0], u[3:0]}); i_tex_data input 16 (RGB565, valid exactly 1 cycle after o_tex_rd_en).
REQ-004 SHALL have pixel output ports: o_pix_valid output 1; o_pix_data output 16; o_pix_idx output 8 ({py[3:0], px[3:0]}); i_pix_ready input 1.
REQ-005 SHALL have o_busy output 1 (state != IDLE).

Function
REQ-006 SHALL hold an internal 256-entry tile buffer, each entry 16-bit colour plus 8-bit depth, indexed {py,px}.
REQ-007 SHALL implement states IDLE, RENDER, DRAIN, OUTPUT; o_job_ready = 1 only in IDLE.
REQ-008 IDLE: on i_job_valid&o_job_ready, SHALL latch start_x, start_y, z, texture_idx, tile_last, clear pixel counter to 0, go to RENDER.
REQ-009 RENDER: SHALL step pixel counter 0..255 one per cycle, raster order (px fastest); go to DRAIN after pixel 255.
REQ-010 For pixel (px,py): u = px+16-start_x, v = py+16-start_y, computed 6-bit signed; in-range iff 0<=u<=15 and 0<=v<=15.
REQ-011 SHALL assert o_tex_rd_en only for in-range pixels, o_tex_addr = {texture_idx, v[3:0], u[3:0]}.
REQ-012 One cycle after each read, SHALL write the returned texel and z to the buffer entry iff z == 0 or z >= stored depth; later job wins on ties.
REQ-013 DRAIN: SHALL take exactly 1 cycle to retire the final read; then go to OUTPUT if latched tile_last = 1, else IDLE.
REQ-014 Per-job latency SHALL be 258 cycles from acceptance to o_job_ready re-asserting (non-last job).
REQ-015 start_x = 0 or start_y = 0 (no overlap) SHALL still run 256 RENDER cycles with zero reads and no buffer change.
REQ-016 OUTPUT: SHALL present entries 0..255 in index order on o_pix_data/o_pix_idx with o_pix_valid = 1; advance only on o_pix_valid&i_pix_ready; data/idx SHALL hold stable while stalled.
REQ-017 On each accepted output pixel SHALL reset that entry to colour 0, depth 0.
REQ-018 After pixel 255 accepted SHALL return to IDLE the next cycle.
REQ-019 Upstream SHALL hold job fields stable while i_job_valid=1 and o_job_ready=0; the block SHALL NOT drop or duplicate jobs.

Reset
REQ-020 On reset_n = 0, asynchronously: state IDLE, o_job_ready 1, o_tex_rd_en 0, o_tex_addr 0, o_pix_valid 0, o_pix_data 0, o_pix_idx 0, o_busy 0, counters 0.
REQ-021 Reset mid-RENDER or mid-OUTPUT SHALL abort the job/stream; tile buffer contents after reset are undefined until fully overwritten by a background job.

Configuration
REQ-022 Macro TILE_COMPOSITOR_TRANSPARENCY_EN: when defined, a texel value 16'h0000 from a job with z != 0 SHALL NOT be written; when undefined, all in-range texels obey REQ-012 only.

Verification
REQ-023 Background job (start 16,16, z 0, tex 8'h05, last 1), texture = address low byte -> 256 reads addr 16'h0500..16'h05FF, then output pixel i = i.
REQ-024 Background then sprite (start 20,18, z 3, last 1) -> sprite reads only for px>=4, py>=2 (168 reads), u=px-4; output shows sprite texels there, background elsewhere.
REQ-025 Two overlapping sprites z 5 then z 2 over background -> z 5 texels remain in overlap; repeat with z 5 then z 5 -> second wins.
REQ-026 Sprite texel 0 with TILE_COMPOSITOR_TRANSPARENCY_EN defined -> background pixel kept; undefined -> pixel becomes 0.
REQ-027 OUTPUT with i_pix_ready toggling every 3 cycles -> 256 pixels, no skip/repeat, stable while stalled; next tile output all 0 where unwritten.
REQ-028 reset_n pulse at RENDER pixel 100 -> all outputs at REQ-020 values immediately; next job accepted normally.
